axi4stream_frame_deserializer: RTL and testbench

Parametrised AXI4-Stream slave that assembles a fixed number of beats into one wide buffer word and presents it on a valid/ready output. It sits between the DMA MM2S stream and the upscaler datapath, replacing the always-ready single-register input buffer. It adds:
- real backpressure through a double-buffered assemble/output pair;
- a partial-width final beat;
- tlast framing checks;
- a completed-frame counter.

---
 rtl/axi4stream_frame_deserializer_if.sv | 28 ++
 rtl/axi4stream_frame_deserializer.sv | 156 +++++++++++++++
 tb/tb_axi4stream_frame_deserializer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4stream_frame_deserializer_if.sv
// rtl/axi4stream_frame_deserializer_if.sv - stream-in / frame-out handshake bundle for the frame deserializer
//
// Carries the AXI4-Stream input (s_tdata/s_tvalid/s_tlast/s_tready) and the
// wide-word output handshake (m_buffer/m_valid/m_ready).
//   slave  : deserializer view (consumes the stream, produces the frame)
//   master : producer/consumer view (drives the stream, takes the frame)
interface axi4stream_frame_deserializer_if #(
  parameter int AXI_WIDTH    = 32,
  parameter int BUFFER_WIDTH = 32 * 32
) ();
  logic [AXI_WIDTH-1:0]    s_tdata;
  logic                    s_tvalid;
  logic                    s_tlast;
  logic                    s_tready;
  logic [BUFFER_WIDTH-1:0] m_buffer;
  logic                    m_valid;
  logic                    m_ready;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_ready,
    output s_tready, m_buffer, m_valid
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_ready,
    input  s_tready, m_buffer, m_valid
  );
endinterface

// File: rtl/axi4stream_frame_deserializer.sv
// rtl/axi4stream_frame_deserializer.sv - assembles BEATS stream beats into one wide double-buffered output word
//
// Ports:
//   aclk             : clock, rising edge
//   areset           : synchronous active-high reset
//   bus (slave)      : s_tdata/s_tvalid/s_tlast/s_tready in, m_buffer/m_valid/m_ready out
//   err_early_last   : one-cycle pulse, tlast seen before the final beat (frame dropped)
//   err_missing_last : one-cycle pulse, final beat arrived without tlast (frame kept)
//   frame_count      : frames moved into the output register, wraps
module axi4stream_frame_deserializer #(
  parameter int AXI_WIDTH       = 32,
  parameter int BEATS           = 32,
  parameter int LAST_BEAT_WIDTH = AXI_WIDTH,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                               aclk,
  input  logic                               areset,
  axi4stream_frame_deserializer_if.slave     bus,
  output logic                               err_early_last,
  output logic                               err_missing_last,
  output logic [CNT_WIDTH-1:0]               frame_count
);

  localparam int BUFFER_WIDTH = (BEATS - 1) * AXI_WIDTH + LAST_BEAT_WIDTH;
  localparam int IDX_W        = $clog2(BEATS);

  // FILL: accepting beats. HOLD: a complete frame sits in the assemble
  // register waiting for the output register to drain.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BUFFER_WIDTH-1:0] assemble_q, assemble_d;
  logic [BUFFER_WIDTH-1:0] m_buffer_q, m_buffer_d;
  logic                    m_valid_q, m_valid_d;
  logic [CNT_WIDTH-1:0]    frame_count_q, frame_count_d;
  logic                    err_early_q, err_early_d;
  logic                    err_missing_q, err_missing_d;

  logic                    s_tready;
  logic                    accept;
  logic                    consume;
  logic                    out_free;
  logic                    last_beat;
  logic                    transfer;
  logic [BUFFER_WIDTH-1:0] xfer_data;

  // Ready depends only on state and reset so it never loops back through
  // the producer's tvalid or the consumer's ready.
  assign s_tready  = (state_q == FILL) && !areset;
  assign accept    = bus.s_tvalid && s_tready;
  assign consume   = m_valid_q && bus.m_ready;
  assign out_free  = !m_valid_q || bus.m_ready;
  assign last_beat = (idx_q == IDX_W'(BEATS - 1));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    assemble_d    = assemble_q;
    m_buffer_d    = m_buffer_q;
    m_valid_d     = m_valid_q;
    frame_count_d = frame_count_q;
    err_early_d   = 1'b0;
    err_missing_d = 1'b0;
    transfer      = 1'b0;
    xfer_data     = assemble_q;

    // Beat write into its slot; the final slot keeps only the low bits.
    if (accept) begin
      for (int b = 0; b < BEATS - 1; b++) begin
        if (idx_q == IDX_W'(b)) begin
          assemble_d[b*AXI_WIDTH +: AXI_WIDTH] = bus.s_tdata;
        end
      end
      if (last_beat) begin
        assemble_d[(BEATS-1)*AXI_WIDTH +: LAST_BEAT_WIDTH] = bus.s_tdata[LAST_BEAT_WIDTH-1:0];
      end
    end

    case (state_q)
      FILL: begin
        if (accept) begin
          if (last_beat) begin
            idx_d         = '0;
            err_missing_d = !bus.s_tlast;
            if (out_free) begin
              // Forward the frame including the beat landing this cycle.
              transfer  = 1'b1;
              xfer_data = assemble_d;
            end else begin
              state_d = HOLD;
            end
          end else if (bus.s_tlast) begin
            // Short frame: drop it and restart at beat 0.
            idx_d       = '0;
            err_early_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (consume) begin
          transfer = 1'b1;
          state_d  = FILL;
        end
      end
    endcase

    // A consume and a transfer in the same cycle keep m_valid high with the
    // new word, so frames leave back to back.
    if (transfer) begin
      m_buffer_d    = xfer_data;
      m_valid_d     = 1'b1;
      frame_count_d = frame_count_q + CNT_WIDTH'(1);
    end else if (consume) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= FILL;
      idx_q         <= '0;
      m_buffer_q    <= '0;
      m_valid_q     <= 1'b0;
      frame_count_q <= '0;
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      m_buffer_q    <= m_buffer_d;
      m_valid_q     <= m_valid_d;
      frame_count_q <= frame_count_d;
      err_early_q   <= err_early_d;
      err_missing_q <= err_missing_d;
    end
  end

  // Every assemble bit is rewritten each frame, so it needs no reset.
  always_ff @(posedge aclk) begin
    assemble_q <= assemble_d;
  end

  assign bus.s_tready     = s_tready;
  assign bus.m_buffer     = m_buffer_q;
  assign bus.m_valid      = m_valid_q;
  assign err_early_last   = err_early_q;
  assign err_missing_last = err_missing_q;
  assign frame_count      = frame_count_q;

endmodule

// File: tb/tb_axi4stream_frame_deserializer.sv
// tb/tb_axi4stream_frame_deserializer.sv - self-checking bench for the frame deserializer
module tb_axi4stream_frame_deserializer;
  localparam int AW  = 8;
  localparam int NB  = 4;
  localparam int LBW = 4;
  localparam int BW  = (NB - 1) * AW + LBW;
  localparam int CW  = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic          err_early_last;
  logic          err_missing_last;
  logic [CW-1:0] frame_count;

  always #5 aclk = ~aclk;

  axi4stream_frame_deserializer_if #(.AXI_WIDTH(AW), .BUFFER_WIDTH(BW)) bus ();

  axi4stream_frame_deserializer #(
    .AXI_WIDTH(AW), .BEATS(NB), .LAST_BEAT_WIDTH(LBW), .CNT_WIDTH(CW)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .bus(bus.slave),
    .err_early_last(err_early_last),
    .err_missing_last(err_missing_last),
    .frame_count(frame_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames that have completed but not yet been consumed,
  // oldest first. Head is what m_buffer must show; at most two fit
  // (output word plus one waiting), so a full queue means backpressure.
  logic [BW-1:0] exp_q[$];
  logic [AW-1:0] mbeats[NB];
  int            nb = 0;
  logic [CW-1:0] total = '0;
  bit            e_early_n = 0;
  bit            e_miss_n  = 0;
  bit            chk_en = 0;

  always @(negedge aclk) begin : model
    bit            exp_valid, exp_tready, accept, consume;
    logic [BW-1:0] f;
    if (chk_en) begin
      exp_valid  = exp_q.size() > 0;
      exp_tready = !areset && exp_q.size() < 2;
      check("s_tready", bus.s_tready, exp_tready);
      check("m_valid", bus.m_valid, exp_valid);
      if (exp_valid) check("m_buffer", bus.m_buffer, exp_q[0]);
      check("frame_count", frame_count, total - CW'(exp_q.size() == 2 ? 1 : 0));
      check("err_early_last", err_early_last, e_early_n);
      check("err_missing_last", err_missing_last, e_miss_n);

      // Advance to the state after the coming rising edge.
      e_early_n = 0;
      e_miss_n  = 0;
      if (areset) begin
        exp_q.delete();
        nb    = 0;
        total = '0;
      end else begin
        accept  = bus.s_tvalid && exp_tready;
        consume = exp_valid && bus.m_ready;
        if (consume) void'(exp_q.pop_front());
        if (accept) begin
          if (nb < NB - 1 && bus.s_tlast) begin
            nb        = 0;
            e_early_n = 1;
          end else if (nb == NB - 1) begin
            f = '0;
            for (int i = 0; i < NB - 1; i++) f = f | (BW'(mbeats[i]) << (AW * i));
            f = f | (BW'(bus.s_tdata % (1 << LBW)) << (AW * (NB - 1)));
            exp_q.push_back(f);
            total    = total + 1'b1;
            e_miss_n = !bus.s_tlast;
            nb       = 0;
          end else begin
            mbeats[nb] = bus.s_tdata;
            nb++;
          end
        end
      end
    end
  end

  task automatic beat(input logic [AW-1:0] d, input bit l);
    int n;
    n = 0;
    bus.s_tdata  = d;
    bus.s_tvalid = 1'b1;
    bus.s_tlast  = l;
    @(negedge aclk);
    while (!bus.s_tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 200) check("beat_accept_timeout", 0, 1);
    @(posedge aclk);
    #1;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.s_tvalid = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic frame4(input logic [AW-1:0] a, b, c, d, input bit l);
    beat(a, 1'b0);
    beat(b, 1'b0);
    beat(c, 1'b0);
    beat(d, l);
  endtask

  task automatic pulse_reset();
    areset = 1'b1;
    @(negedge aclk);
    check("reset_s_tready", bus.s_tready, 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("reset_m_valid", bus.m_valid, 0);
    check("reset_frame_count", frame_count, 0);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset       = 1'b1;
    bus.s_tdata  = '0;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.m_ready  = 1'b1;
    @(posedge aclk);
    #1;
    chk_en = 1;
    @(negedge aclk);
    check("por_m_buffer", bus.m_buffer, 0);
    check("por_frame_count", frame_count, 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    idle(2);

    // Basic frame
    frame4(8'h11, 8'h22, 8'h33, 8'hA4, 1'b1);
    @(negedge aclk);
    check("basic_m_valid", bus.m_valid, 1);
    check("basic_m_buffer", bus.m_buffer, 28'h4332211);
    check("basic_count", frame_count, 1);
    @(posedge aclk);
    #1;
    idle(2);

    // Backpressure
    bus.m_ready = 1'b0;
    frame4(8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
    frame4(8'h05, 8'h06, 8'h07, 8'h08, 1'b1);
    @(negedge aclk);
    check("bp_s_tready_low", bus.s_tready, 0);
    check("bp_held_buffer", bus.m_buffer, 28'h4030201);
    check("bp_count_held", frame_count, 2);
    @(posedge aclk);
    #1;
    bus.m_ready = 1'b1;
    @(posedge aclk);
    #1;
    bus.m_ready = 1'b0;
    @(negedge aclk);
    check("bp_second_buffer", bus.m_buffer, 28'h8070605);
    check("bp_m_valid", bus.m_valid, 1);
    check("bp_s_tready_back", bus.s_tready, 1);
    check("bp_count", frame_count, 3);
    @(posedge aclk);
    #1;
    bus.m_ready = 1'b1;
    idle(3);

    // Early tlast
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b1);
    @(negedge aclk);
    check("early_err", err_early_last, 1);
    check("early_m_valid", bus.m_valid, 0);
    @(posedge aclk);
    #1;
    frame4(8'h11, 8'h22, 8'h33, 8'h04, 1'b1);
    @(negedge aclk);
    check("early_next_buffer", bus.m_buffer, 28'h4332211);
    check("early_next_count", frame_count, 4);
    @(posedge aclk);
    #1;

    // Missing tlast
    frame4(8'h11, 8'h22, 8'h33, 8'h04, 1'b0);
    @(negedge aclk);
    check("miss_err", err_missing_last, 1);
    check("miss_buffer", bus.m_buffer, 28'h4332211);
    check("miss_count", frame_count, 5);
    @(posedge aclk);
    #1;
    frame4(8'h55, 8'h66, 8'h77, 8'h88, 1'b1);
    @(negedge aclk);
    check("miss_next_buffer", bus.m_buffer, 28'h8776655);
    check("miss_next_count", frame_count, 6);
    @(posedge aclk);
    #1;
    idle(2);

    // Reset mid-frame
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    pulse_reset();
    frame4(8'h11, 8'h22, 8'h33, 8'h04, 1'b1);
    @(negedge aclk);
    check("rst_next_buffer", bus.m_buffer, 28'h4332211);
    check("rst_next_count", frame_count, 1);
    @(posedge aclk);
    #1;
    idle(2);

    // Streaming: 300 frames with random gaps, checked cycle by cycle
    pulse_reset();
    for (int fr = 0; fr < 300; fr++) begin
      for (int bt = 0; bt < NB; bt++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        beat(AW'($urandom_range(0, 255)), bt == NB - 1);
      end
    end
    idle(4);
    @(negedge aclk);
    check("stream_count", frame_count, 16'd300);
    check("stream_drained", bus.m_valid, 0);
    @(posedge aclk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
